// File: rtl/demux_pkg.sv
// Shared types and constants for the classifier output stream router.
package demux_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_CNT_W  = 16;

    typedef logic [1:0] dest_t;

    localparam dest_t DEST_DISP = 2'b00;
    localparam dest_t DEST_UART = 2'b01;
    localparam dest_t DEST_MEM  = 2'b10;
    localparam dest_t DEST_DROP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ROUTE = 2'b01,
        ST_DROP  = 2'b10
    } state_t;

    // True when a destination code means "discard the frame".
    function automatic logic is_drop(input dest_t d);
        return d == DEST_DROP;
    endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// Single-entry valid/ready register stage carrying {data, last, dest}.
// Loads and drains in the same cycle, so a ready sink sees one word per cycle.
module stream_reg_slice
    import demux_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  dest_t             in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output dest_t             out_dest
);

    logic              valid_q, valid_d;
    logic              last_q,  last_d;
    dest_t             dest_q,  dest_d;
    logic [DATA_W-1:0] data_q,  data_d;

    // The entry can take a new word when empty or when its word leaves this cycle.
    assign in_ready = !valid_q || out_ready;

    // Next entry contents: load wins over drain, otherwise hold.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        valid_d = valid_q;
        last_d  = last_q;
        dest_d  = dest_q;
        data_d  = data_q;
        if (in_valid && in_ready) begin
            valid_d = 1'b1;
            last_d  = in_last;
            dest_d  = in_dest;
            data_d  = in_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Entry register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the payload is reset too, because the sink data outputs must read 0 after reset.
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            dest_q  <= DEST_DISP;
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            valid_q <= valid_d;
            last_q  <= last_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_dest  = dest_q;

endmodule

// File: rtl/output_demux.sv
// Routes each classifier result frame to display, UART or memory, or drops it.
// The destination is taken from sel on the first word and held for the frame.
module output_demux
    import demux_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_disp_data,
    output logic              out_disp_valid,
    output logic              out_disp_last,
    input  logic              out_disp_ready,
    output logic [DATA_W-1:0] out_uart_data,
    output logic              out_uart_valid,
    output logic              out_uart_last,
    input  logic              out_uart_ready,
    output logic [DATA_W-1:0] out_mem_data,
    output logic              out_mem_valid,
    output logic              out_mem_last,
    input  logic              out_mem_ready,
    output logic              busy,
    output logic [1:0]        active_dest,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    state_t            state_q, state_d;
    dest_t             dest_q, dest_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    dest_t             word_dest;
    logic              word_drop;
    logic              accept;

    logic              slice_in_valid;
    logic              slice_in_ready;
    logic              reg_valid;
    logic              reg_last;
    logic              reg_ready;
    dest_t             reg_dest;
    logic [DATA_W-1:0] reg_data;

    // Destination of the word on the input: live sel at frame start, latched afterwards.
    always_comb begin
        word_dest = (state_q == ST_IDLE) ? dest_t'(sel) : dest_q;
        word_drop = is_drop(word_dest);
    end

    // Dropped words bypass the register; routed words wait for a free entry.
    assign in_ready       = !rst && (word_drop || slice_in_ready);
    assign accept         = in_valid && in_ready;
    assign slice_in_valid = in_valid && !word_drop;

    stream_reg_slice #(
        .DATA_W (DATA_W)
    ) u_slice (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (slice_in_valid),
        .in_ready  (slice_in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_dest   (word_dest),
        .out_valid (reg_valid),
        .out_ready (reg_ready),
        .out_data  (reg_data),
        .out_last  (reg_last),
        .out_dest  (reg_dest)
    );

    // State and latched destination register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dest_q  <= DEST_DISP;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
        end
    end

    // Next state: a frame opens on its first accepted word and closes on its last.
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !in_last) begin
                    dest_d  = word_dest;
                    state_d = word_drop ? ST_DROP : ST_ROUTE;
                end
            end
            ST_ROUTE, ST_DROP: begin
                if (accept && in_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: status, per-sink fan-out of the shared register, and the sink ready it waits on.
    always_comb begin
        busy           = (state_q != ST_IDLE);
        active_dest    = (state_q == ST_IDLE) ? DEST_DISP : dest_q;

        out_disp_data  = reg_data;
        out_uart_data  = reg_data;
        out_mem_data   = reg_data;

        out_disp_valid = reg_valid && (reg_dest == DEST_DISP);
        out_uart_valid = reg_valid && (reg_dest == DEST_UART);
        out_mem_valid  = reg_valid && (reg_dest == DEST_MEM);

        out_disp_last  = out_disp_valid && reg_last;
        out_uart_last  = out_uart_valid && reg_last;
        out_mem_last   = out_mem_valid  && reg_last;

        case (reg_dest)
            DEST_DISP: reg_ready = out_disp_ready;
            DEST_UART: reg_ready = out_uart_ready;
            DEST_MEM:  reg_ready = out_mem_ready;
            default:   reg_ready = 1'b0;
        endcase
    end

    // Frame counter steps when a last word leaves toward a sink; drop counter on a discarded last word.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (reg_valid && reg_ready && reg_last) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
        if (accept && word_drop && in_last) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Counter registers; both wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_output_demux.sv
// Testbench for output_demux: directed frames from the test plan, then randomized
// frames with random sink backpressure, all checked against a per-sink queue model.
module tb_output_demux;
    import demux_pkg::*;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [1:0]        sel = 2'b00;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] out_disp_data, out_uart_data, out_mem_data;
    logic              out_disp_valid, out_uart_valid, out_mem_valid;
    logic              out_disp_last, out_uart_last, out_mem_last;
    logic              out_disp_ready, out_uart_ready, out_mem_ready;
    logic              busy;
    logic [1:0]        active_dest;
    logic [CNT_W-1:0]  frame_cnt, drop_cnt;

    logic [2:0] rdy_dir = 3'b111;
    logic [2:0] rnd_rdy = 3'b111;
    logic       rand_rdy = 1'b0;
    logic [2:0] rdy, vld;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign rdy = rand_rdy ? rnd_rdy : rdy_dir;
    assign out_disp_ready = rdy[0];
    assign out_uart_ready = rdy[1];
    assign out_mem_ready  = rdy[2];
    assign vld = {out_mem_valid, out_uart_valid, out_disp_valid};

    output_demux #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .sel            (sel),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .out_disp_data  (out_disp_data),
        .out_disp_valid (out_disp_valid),
        .out_disp_last  (out_disp_last),
        .out_disp_ready (out_disp_ready),
        .out_uart_data  (out_uart_data),
        .out_uart_valid (out_uart_valid),
        .out_uart_last  (out_uart_last),
        .out_uart_ready (out_uart_ready),
        .out_mem_data   (out_mem_data),
        .out_mem_valid  (out_mem_valid),
        .out_mem_last   (out_mem_last),
        .out_mem_ready  (out_mem_ready),
        .busy           (busy),
        .active_dest    (active_dest),
        .frame_cnt      (frame_cnt),
        .drop_cnt       (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [DATA_W-1:0] sink_data(input int d);
        case (d)
            0:       return out_disp_data;
            1:       return out_uart_data;
            default: return out_mem_data;
        endcase
    endfunction

    function automatic logic sink_last(input int d);
        case (d)
            0:       return out_disp_last;
            1:       return out_uart_last;
            default: return out_mem_last;
        endcase
    endfunction

    // ---------------- reference model ----------------
    // Per-sink queues of {last, data} in arrival order; frame destination from its first word.
    logic [16:0] q_disp[$];
    logic [16:0] q_uart[$];
    logic [16:0] q_mem[$];
    bit          m_open = 0;
    logic [1:0]  m_dest = 2'b00;
    int unsigned m_frames = 0;
    int unsigned m_drops = 0;
    bit          pend = 0;
    int          pend_dest = 0;
    logic [15:0] pend_data = '0;

    task automatic pop_check(input int d);
        logic [16:0] e;
        int sz;
        case (d)
            0:       sz = q_disp.size();
            1:       sz = q_uart.size();
            default: sz = q_mem.size();
        endcase
        check($sformatf("sink%0d_expected_word", d), 32'(sz != 0), 1);
        if (sz != 0) begin
            case (d)
                0:       e = q_disp.pop_front();
                1:       e = q_uart.pop_front();
                default: e = q_mem.pop_front();
            endcase
            check($sformatf("sink%0d_word", d), {15'd0, sink_last(d), sink_data(d)}, {15'd0, e});
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q_disp.delete(); q_uart.delete(); q_mem.delete();
            m_open = 0; m_frames = 0; m_drops = 0; pend = 0;
        end else begin
            if (pend) begin
                check($sformatf("latency_valid_sink%0d", pend_dest), 32'(vld[pend_dest]), 1);
                check("latency_data", 32'(sink_data(pend_dest)), 32'(pend_data));
            end
            check("valid_onehot", 32'($countones(vld) <= 1), 1);
            for (int d = 0; d < 3; d++) if (vld[d] && rdy[d]) pop_check(d);
            if (m_open && m_dest == DEST_DROP && in_valid) check("drop_in_ready", 32'(in_ready), 1);
            pend = 0;
            if (in_valid && in_ready) begin
                if (!m_open) m_dest = sel;
                if (m_dest == DEST_DROP) begin
                    if (in_last) m_drops++;
                end else begin
                    case (m_dest)
                        DEST_DISP: q_disp.push_back({in_last, in_data});
                        DEST_UART: q_uart.push_back({in_last, in_data});
                        default:   q_mem.push_back({in_last, in_data});
                    endcase
                    if (in_last) m_frames++;
                    pend = 1; pend_dest = int'(m_dest); pend_data = in_data;
                end
                m_open = !in_last;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    initial begin
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) rnd_rdy[i] = ($urandom_range(3) != 0);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_word(input logic [1:0] s, input logic [15:0] d, input logic l, input int gap);
        bit done = 0;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            sync();
        end
        sel = s; in_data = d; in_last = l; in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
                break;
            end
        end
        if (!done) check("accept_timeout", 32'(in_ready), 1);
        sync();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (q_disp.size() == 0 && q_uart.size() == 0 && q_mem.size() == 0 && vld == 3'b000) begin
                done = 1;
                break;
            end
        end
        check("drain", 32'(done), 1);
        sync();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_valids", 32'(vld), 0);
        check("rst_lasts", {29'd0, out_mem_last, out_uart_last, out_disp_last}, 0);
        check("rst_data", 32'(out_disp_data | out_uart_data | out_mem_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_active_dest", 32'(active_dest), 0);
        check("rst_counters", {frame_cnt, drop_cnt}, 0);
        @(negedge clk);
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 1);
        sync();

        // Test 1: 4-word display frame, sink always ready, back-to-back.
        rdy_dir = 3'b111;
        for (int i = 0; i < 4; i++) begin
            sel = DEST_DISP; in_data = 16'((i + 1) * 256); in_last = (i == 3); in_valid = 1'b1;
            @(negedge clk);
            check("t1_in_ready", 32'(in_ready), 1);
            sync();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_last_on_disp", {30'd0, out_disp_valid, out_disp_last}, 3);
        check("t1_last_data", 32'(out_disp_data), 32'h0400);
        sync();
        @(negedge clk);
        check("t1_frame_cnt", 32'(frame_cnt), 1);
        check("t1_busy", 32'(busy), 0);
        sync();

        // Test 2: 3-word UART frame, sink stalls for 2 cycles after the first word.
        rdy_dir = 3'b010;
        send_word(DEST_UART, 16'h0100, 1'b0, 0);
        sel = DEST_UART; in_data = 16'h0200; in_last = 1'b0; in_valid = 1'b1;
        rdy_dir = 3'b000;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("t2_stall_in_ready", 32'(in_ready), 0);
            check("t2_held_valid", 32'(out_uart_valid), 1);
            check("t2_held_data", 32'(out_uart_data), 32'h0100);
            sync();
        end
        rdy_dir = 3'b010;
        @(negedge clk);
        check("t2_resume_in_ready", 32'(in_ready), 1);
        sync();
        send_word(DEST_UART, 16'h0300, 1'b1, 0);
        wait_drain();
        check("t2_frame_cnt", 32'(frame_cnt), 2);

        // Test 3: memory frame with sel changing mid-frame, then a display frame.
        rdy_dir = 3'b111;
        send_word(DEST_MEM, 16'h0B01, 1'b0, 0);
        @(negedge clk);
        check("t3_active_dest", 32'(active_dest), 32'(DEST_MEM));
        check("t3_busy", 32'(busy), 1);
        sync();
        send_word(DEST_DISP, 16'h0B02, 1'b0, 0);
        send_word(DEST_DISP, 16'h0B03, 1'b1, 0);
        send_word(DEST_DISP, 16'h0C01, 1'b0, 0);
        send_word(DEST_UART, 16'h0C02, 1'b1, 0);
        wait_drain();
        check("t3_frame_cnt", 32'(frame_cnt), 4);
        check("t3_idle_active_dest", 32'(active_dest), 0);

        // Test 4: 5-word dropped frame, all sinks stalled.
        rdy_dir = 3'b000;
        for (int i = 0; i < 5; i++) begin
            sel = (i == 0) ? DEST_DROP : 2'($urandom_range(3));
            in_data = 16'($urandom); in_last = (i == 4); in_valid = 1'b1;
            @(negedge clk);
            check("t4_in_ready", 32'(in_ready), 1);
            check("t4_no_valid", 32'(vld), 0);
            sync();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_drop_cnt", 32'(drop_cnt), 1);
        check("t4_frame_cnt", 32'(frame_cnt), 4);
        check("t4_busy", 32'(busy), 0);
        sync();

        // Test 5: single-word UART frame back-to-back with a memory frame.
        rdy_dir = 3'b111;
        sel = DEST_UART; in_data = 16'h7FFF; in_last = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        check("t5_in_ready", 32'(in_ready), 1);
        sync();
        sel = DEST_MEM; in_data = 16'h1111; in_last = 1'b0;
        @(negedge clk);
        check("t5_uart_valid", 32'(out_uart_valid), 1);
        check("t5_uart_data", 32'(out_uart_data), 32'h7FFF);
        check("t5_busy_single", 32'(busy), 0);
        check("t5_in_ready2", 32'(in_ready), 1);
        sync();
        in_data = 16'h1112; in_last = 1'b1;
        @(negedge clk);
        check("t5_mem_valid", {30'd0, out_uart_valid, out_mem_valid}, 1);
        check("t5_mem_data", 32'(out_mem_data), 32'h1111);
        sync();
        in_valid = 1'b0;
        wait_drain();
        check("t5_frame_cnt", 32'(frame_cnt), 6);

        // Test 6: reset after 2 of 4 words, then a fresh display frame.
        send_word(DEST_DISP, 16'hA001, 1'b0, 0);
        send_word(DEST_DISP, 16'hA002, 1'b0, 0);
        rdy_dir = 3'b000;
        @(negedge clk);
        check("t6_pre_rst_valid", 32'(out_disp_valid), 1);
        rst = 1'b1;
        #1;
        check("t6_rst_valids", 32'(vld), 0);
        check("t6_rst_counters", {frame_cnt, drop_cnt}, 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        sync();
        rst = 1'b0;
        rdy_dir = 3'b111;
        @(negedge clk);
        check("t6_post_in_ready", 32'(in_ready), 1);
        check("t6_post_busy", 32'(busy), 0);
        sync();
        send_word(DEST_DISP, 16'h0D01, 1'b0, 0);
        send_word(DEST_DISP, 16'h0D02, 1'b1, 0);
        wait_drain();
        check("t6_frame_cnt", 32'(frame_cnt), 1);

        // Randomized frames with random sel, gaps, mid-frame sel noise and sink backpressure.
        rand_rdy = 1'b1;
        for (int f = 0; f < 300; f++) begin
            int len;
            logic [1:0] s;
            s   = 2'($urandom_range(3));
            len = $urandom_range(1, 6);
            for (int w = 0; w < len; w++) begin
                send_word((w == 0) ? s : 2'($urandom_range(3)), 16'($urandom), (w == len - 1),
                          ($urandom_range(3) == 0) ? 1 : 0);
            end
        end
        rand_rdy = 1'b0;
        rdy_dir  = 3'b111;
        wait_drain();
        check("rand_frame_cnt", 32'(frame_cnt), 32'(m_frames[15:0]));
        check("rand_drop_cnt", 32'(drop_cnt), 32'(m_drops[15:0]));
        check("rand_busy", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
